// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline latch.
// Owns the PC, issues I-cache reads and applies the hazard unit's stall and
// flush. Branch/jump redirects also act here. Decode sees {instr, PC+4, valid}.
// A fetched HALT parks the stage in HALT_PEND. If it is not squashed there,
// the stage moves to HALTED and instruction reads stay quiet until reset.
// Ports:
//   CLK, RST         clock, asynchronous active-high reset
//   ihit, imemload   I-cache hit strobe and returned instruction word
//   imemREN          read enable, high only while fetching
//   imemaddr         current PC
//   stall, flush     hazard-unit hold / squash of IF/ID
//   redirect_valid   taken branch/jump target present this cycle
//   redirect_pc      target PC; low two bits forced to zero
//   ifid_instr       latched instruction (0 when invalid)
//   ifid_npc         latched PC+4
//   ifid_valid       IF/ID holds a real instruction
//   halted           sticky HALT-committed flag
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid,
  output logic        halted
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   target;
  logic              is_halt;

  // Address arithmetic; PC+4 wraps naturally modulo 2^32.
  assign pc_plus4 = pc + XLEN'(4);
  assign target   = {redirect_pc[XLEN-1:2], 2'b00};
  assign is_halt  = (imemload[31:26] == HALT_OP);

  assign imemaddr = pc;
  assign imemREN  = (state == FETCH);

  // PC, IF/ID latch and halt sequencing.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= FETCH;
      pc         <= PC_INIT;
      ifid_instr <= '0;
      ifid_npc   <= '0;
      ifid_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (flush) begin
            ifid_instr <= '0;
            ifid_npc   <= '0;
            ifid_valid <= 1'b0;
            if (redirect_valid) pc <= target;
          end else if (redirect_valid) begin
            pc         <= target;
            ifid_instr <= '0;
            ifid_npc   <= '0;
            ifid_valid <= 1'b0;
          end else if (stall) begin
            // hold PC and IF/ID even on a hit; the word is refetched later
          end else if (ihit) begin
            ifid_instr <= imemload;
            ifid_npc   <= pc_plus4;
            ifid_valid <= 1'b1;
            // A HALT freezes the PC so a squash can restart cleanly
            if (is_halt) state <= HALT_PEND;
            else         pc    <= pc_plus4;
          end else begin
            ifid_instr <= '0;
            ifid_npc   <= '0;
            ifid_valid <= 1'b0;
          end
        end

        HALT_PEND: begin
          if (flush) begin
            // The HALT was on a squashed path: resume fetching
            ifid_instr <= '0;
            ifid_npc   <= '0;
            ifid_valid <= 1'b0;
            if (redirect_valid) pc <= target;
            state <= FETCH;
          end else if (stall) begin
            // HALT held in IF/ID until decode accepts it
          end else begin
            ifid_instr <= '0;
            ifid_npc   <= '0;
            ifid_valid <= 1'b0;
            halted     <= 1'b1;
            state      <= HALTED;
          end
        end

        HALTED: begin
          // Terminal until reset; all hazard inputs ignored
        end

        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule
